sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//   Single-clock FIFO controller; drives both ports of an external RAM_DUAL_rst (w_clk=r_clk=clk).
//   Owns wr/rd pointers, occupancy, status flags, sticky error flags; RAM stores data.
//   Standard (non-FWFT) read: rd_data valid one cycle after accepted rd_en, marked by rd_valid.
// PARAMETERS
//   ADDR_WIDTH  10  RAM address width; FIFO depth = 2**ADDR_WIDTH
//   DATA_WIDTH  32  data word width
//   AF_LEVEL    2**ADDR_WIDTH-4  almost_full when count >= AF_LEVEL (1..depth)
//   AE_LEVEL    4   almost_empty when count <= AE_LEVEL (0..depth-1)
// PORTS
//   clk           in   1             single clock; also drives RAM w_clk and r_clk
//   rst           in   1             synchronous, active-high reset
//   wr_en         in   1             push request
//   wr_data       in   DATA_WIDTH    push data
//   full          out  1             FIFO holds depth words
//   almost_full   out  1             count >= AF_LEVEL
//   rd_en         in   1             pop request
//   rd_data       out  DATA_WIDTH    popped word (= ram_r_data), qualified by rd_valid
//   rd_valid      out  1             rd_data valid this cycle
//   empty         out  1             FIFO holds 0 words
//   almost_empty  out  1             count <= AE_LEVEL
//   count         out  ADDR_WIDTH+1  current occupancy, 0..depth
//   overflow      out  1             sticky: push attempted while full
//   underflow     out  1             sticky: pop attempted while empty
//   ram_w_en/ram_w_addr/ram_w_data  out 1/ADDR_WIDTH/DATA_WIDTH  RAM write port
//   ram_r_en/ram_r_addr             out 1/ADDR_WIDTH             RAM read port
//   ram_r_data    in   DATA_WIDTH    RAM registered read data (1-cycle latency)
//   ram_rst_n     out  1             RAM reset = ~rst (combinational)
// BEHAVIOUR
//   - wr_ptr, rd_ptr: ADDR_WIDTH+1 bit registers; RAM address = low ADDR_WIDTH bits; MSB = wrap bit.
//   - empty = (wr_ptr == rd_ptr); full = low bits equal AND MSBs differ; count = wr_ptr - rd_ptr (mod 2**(AW+1)).
//   - All flags/count derive from registered pointers: they reflect state at start of cycle.
//   - push = wr_en & ~full; pop = rd_en & ~empty (evaluated on start-of-cycle flags).
//   - ram_w_en = push, ram_w_addr = wr_ptr[AW-1:0], ram_w_data = wr_data (combinational).
//   - ram_r_en = pop, ram_r_addr = rd_ptr[AW-1:0] (combinational); rd_data = ram_r_data.
//   - rd_valid <= pop (1-cycle latency); rd_data holds last value when rd_valid=0.
//   - push: wr_ptr+1; pop: rd_ptr+1; both: both advance, count unchanged. Pointers wrap naturally.
//   - Full + wr_en + rd_en: pop accepted, push rejected, overflow set, count decrements.
//   - Empty + wr_en + rd_en: push accepted, pop rejected, underflow set, rd_valid=0 next cycle.
//   - Rejected push: no RAM write, wr_ptr unchanged. Rejected pop: no ram_r_en, rd_ptr unchanged.
//   - Read/write same RAM address in one cycle cannot occur (pop needs !empty, push needs !full).
//   - overflow/underflow: set on rejected request, cleared only by rst.
//   - Reset (rst=1 at posedge): pointers=0, rd_valid=0, overflow=0, underflow=0 -> empty=1, full=0,
//     count=0, almost_empty=1, almost_full=0; ram_w_en=ram_r_en=0 while rst=1; ram_rst_n=0 clears RAM
//     and rd_data=0. Reset mid-operation discards contents and any in-flight read (rd_valid=0 next cycle).
// TESTING (ADDR_WIDTH=2, DATA_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
//   1. rst 2 cycles -> empty=1, full=0, count=0, almost_empty=1, rd_valid=0, overflow=underflow=0, rd_data=0.
//   2. push 11,22,33,44 -> almost_full at count 3, full at 4; push 55 -> ram_w_en=0, count=4, overflow=1.
//   3. 5 pops from full -> rd_data 11,22,33,44 each with rd_valid one cycle after rd_en; 5th pop -> rd_valid=0, underflow=1.
//   4. 10 words streamed with interleaved push/pop (pointers wrap twice) -> output order preserved, count never >4.
//   5. count=4, wr_en=rd_en=1 -> count=3, overflow=1; count=2, wr_en=rd_en=1 -> count=2, no flags, data correct.
//   6. count=3, rd_en=1 in rst cycle -> next cycle empty=1, count=0, rd_valid=0; then push AA, pop -> AA.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO controller. Owns the read/write pointers,
//               occupancy and status/error flags, and drives both ports of an
//               external dual-port RAM that holds the data words. Standard
//               (non-FWFT) read: data appears one cycle after an accepted pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // push side
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    // pop side
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    // status
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    // RAM write port
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    // RAM read port
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data,
    output logic                  ram_rst_n
);

    // Thresholds sized to the occupancy counter so comparisons are width-matched.
    localparam logic [ADDR_WIDTH:0] c_AF_LEVEL = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_AE_LEVEL = (ADDR_WIDTH+1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [ADDR_WIDTH:0] w_count;

    // Status is derived purely from the registered pointers (start-of-cycle view).
    always_comb begin
        w_empty = (wr_ptr_q == rd_ptr_q);
        w_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        w_count = wr_ptr_q - rd_ptr_q;
        // Reset suppresses any RAM access in the cycle it is asserted.
        w_push  = wr_en & ~w_full & ~rst;
        w_pop   = rd_en & ~w_empty & ~rst;
    end

    // Next-state: advance pointers on accepted requests, latch sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = w_pop;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && w_full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && w_empty) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset also drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Output mapping: status flags and combinational RAM port drive.
    always_comb begin
        empty        = w_empty;
        full         = w_full;
        count        = w_count;
        almost_full  = (w_count >= c_AF_LEVEL);
        almost_empty = (w_count <= c_AE_LEVEL);
        overflow     = overflow_q;
        underflow    = underflow_q;
        rd_valid     = rd_valid_q;
        rd_data      = ram_r_data;
        ram_w_en     = w_push;
        ram_w_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
        ram_w_data   = wr_data;
        ram_r_en     = w_pop;
        ram_r_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
        ram_rst_n    = ~rst;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Self-checking bench for sync_fifo_ctrl with a behavioural
//               RAM and a queue-based FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int c_AW = 2;
    localparam int c_DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [c_DW-1:0] wr_data = '0;
    logic            rd_en = 1'b0;
    logic            full, almost_full, rd_valid, empty, almost_empty;
    logic [c_DW-1:0] rd_data;
    logic [c_AW:0]   count;
    logic            overflow, underflow;
    logic            ram_w_en, ram_r_en, ram_rst_n;
    logic [c_AW-1:0] ram_w_addr, ram_r_addr;
    logic [c_DW-1:0] ram_w_data, ram_r_data;

    sync_fifo_ctrl #(
        .ADDR_WIDTH(c_AW),
        .DATA_WIDTH(c_DW),
        .AF_LEVEL  (3),
        .AE_LEVEL  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_w_en    (ram_w_en),
        .ram_w_addr  (ram_w_addr),
        .ram_w_data  (ram_w_data),
        .ram_r_en    (ram_r_en),
        .ram_r_addr  (ram_r_addr),
        .ram_r_data  (ram_r_data),
        .ram_rst_n   (ram_rst_n)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous reset, registered read.
    logic [c_DW-1:0] mem [0:(2**c_AW)-1];
    always @(posedge clk) begin
        if (!ram_rst_n) begin
            for (int i = 0; i < 2**c_AW; i++) mem[i] <= '0;
            ram_r_data <= '0;
        end else begin
            if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
            if (ram_r_en) ram_r_data <= mem[ram_r_addr];
        end
    end

    // Reference model state
    logic [c_DW-1:0] q[$];
    bit              m_ovf = 1'b0;
    bit              m_udf = 1'b0;
    bit              m_valid = 1'b0;
    logic [c_DW-1:0] m_data = '0;
    bit              chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic r, input logic w, input logic rd, input logic [c_DW-1:0] d);
        bit              e_full, e_empty, e_push, e_pop;
        logic [c_DW-1:0] v;
        rst = r; wr_en = w; rd_en = rd; wr_data = d;
        @(negedge clk);
        e_full  = (q.size() == 4);
        e_empty = (q.size() == 0);
        e_push  = !r && w && !e_full;
        e_pop   = !r && rd && !e_empty;
        if (chk_en) begin
            check("count",        32'(count),        32'(q.size()));
            check("empty",        32'(empty),        32'(e_empty));
            check("full",         32'(full),         32'(e_full));
            check("almost_full",  32'(almost_full),  32'(q.size() >= 3));
            check("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
            check("overflow",     32'(overflow),     32'(m_ovf));
            check("underflow",    32'(underflow),    32'(m_udf));
            check("rd_valid",     32'(rd_valid),     32'(m_valid));
            check("rd_data",      32'(rd_data),      32'(m_data));
            check("ram_w_en",     32'(ram_w_en),     32'(e_push));
            check("ram_r_en",     32'(ram_r_en),     32'(e_pop));
            check("ram_rst_n",    32'(ram_rst_n),    32'(!r));
            if (e_push) check("ram_w_data", 32'(ram_w_data), 32'(d));
        end
        if (r) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_data = '0;
        end else begin
            if (w && e_full)  m_ovf = 1'b1;
            if (rd && e_empty) m_udf = 1'b1;
            m_valid = e_pop;
            if (e_pop) begin
                v = q.pop_front();
                m_data = v;
            end
            if (e_push) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int guard;
        logic [c_DW-1:0] vals [5];
        @(posedge clk);
        #1;
        // Reset: the first cycle observes pre-reset state, so checking starts after it
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill to full, then one push too many
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, vals[i]);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain with one pop too many
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Stream 10 words with random interleaving; pointers wrap
        pushed = 0;
        guard  = 0;
        while ((pushed < 10 || q.size() > 0) && guard < 200) begin
            bit w, rd;
            w  = (pushed < 10) && ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 1) != 0);
            if (w && q.size() < 4) pushed++;
            cycle(1'b0, w, rd, 8'(8'hA0 + pushed));
            guard++;
        end
        check("stream_done", 32'(guard < 200), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous push/pop at count 2 and at full, from a clean reset
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 8'h02);
        cycle(1'b0, 1'b1, 1'b1, 8'h03);
        cycle(1'b0, 1'b1, 1'b0, 8'h04);
        cycle(1'b0, 1'b1, 1'b0, 8'h05);
        cycle(1'b0, 1'b1, 1'b1, 8'h06);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-operation with a pop requested in the reset cycle
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'hAA);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 1) != 0),
                  8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
